// File: rtl/rv32_lsu_pkg.sv
// Shared types and decode helpers for the RV32 data-port Wishbone master.
// Size encoding follows the core's sel[1:0]; sel[2] selects unsigned loads.
package rv32_lsu_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10
    } mem_size_e;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_ABORT = 1'b1
    } lsu_state_e;

    // Per-request response tag; ofs is sized for the widest (64-bit) bus.
    typedef struct packed {
        logic      we;
        logic      uns;
        mem_size_e size;
        logic [2:0] ofs;
    } lsu_tag_t;

    function automatic mem_size_e decode_size(input logic [1:0] sel);
        mem_size_e sz;
        case (sel)
            2'b00:   sz = SZ_B;
            2'b01:   sz = SZ_H;
            default: sz = SZ_W;
        endcase
        return sz;
    endfunction

    function automatic logic [3:0] size_be(input mem_size_e sz);
        logic [3:0] be;
        case (sz)
            SZ_B:    be = 4'b0001;
            SZ_H:    be = 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic misaligned(input mem_size_e sz, input logic [1:0] a);
        return (sz == SZ_H && a[0]) || (sz == SZ_W && a != 2'b00);
    endfunction

endpackage

// File: rtl/lsu_tag_fifo.sv
// Synchronous FIFO holding response tags for in-flight bus requests.
// Latency: pushed entry visible at head the cycle after push when empty.
// Backpressure: push ignored when full unless a pop happens in the same cycle.
module lsu_tag_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic [W-1:0] push_dat_i,
    input  logic         pop_i,
    output logic [W-1:0] pop_dat_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign empty_o   = (cnt_q == '0);
    assign full_o    = (cnt_q == CNT_FULL);
    assign do_pop    = pop_i && !empty_o;
    assign do_push   = push_i && (!full_o || do_pop);
    assign pop_dat_o = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + AW'(1);
        if (do_push && !do_pop)      cnt_d = cnt_q + CW'(1);
        else if (!do_push && do_pop) cnt_d = cnt_q - CW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
    end

endmodule

// File: rtl/rv32_data_wb_master.sv
// Pipelined Wishbone B4 master for the RV32 data port with in-order tagged responses.
// Latency: strobe the cycle after grant; rvalid the cycle after ack/err (misaligned: after grant).
// Backpressure: gnt low while strobe is stalled, MAX_OUTST are in flight, or aborting on timeout.
module rv32_data_wb_master
    import rv32_lsu_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MAX_OUTST = 2,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                core_req_i,
    output logic                core_gnt_o,
    input  logic [31:0]         core_addr_i,
    input  logic                core_we_i,
    input  logic [2:0]          core_sel_i,
    input  logic [31:0]         core_wdata_i,
    output logic                core_rvalid_o,
    output logic [31:0]         core_rdata_o,
    output logic                core_err_o,
    output logic                wb_cyc_o,
    output logic                wb_stb_o,
    output logic                wb_we_o,
    output logic [31:0]         wb_adr_o,
    output logic [DATA_W-1:0]   wb_dat_o,
    output logic [DATA_W/8-1:0] wb_sel_o,
    input  logic                wb_stall_i,
    input  logic                wb_ack_i,
    input  logic [DATA_W-1:0]   wb_dat_i,
    input  logic                wb_err_i
);

    localparam int unsigned NB    = DATA_W / 8;
    localparam int unsigned OFS_W = $clog2(NB);
    localparam int unsigned CNT_W = $clog2(MAX_OUTST + 1);
    localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUTST);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    lsu_state_e        state_q, state_d;
    logic              stb_q, stb_d;
    logic              cyc_q, cyc_d;
    logic              we_q, we_d;
    logic [31:0]       adr_q, adr_d;
    logic [DATA_W-1:0] dat_q, dat_d;
    logic [NB-1:0]     sel_q, sel_d;
    logic [CNT_W-1:0]  outst_q, outst_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic              rvalid_q, rvalid_d;
    logic              err_q, err_d;
    logic [31:0]       rdata_q, rdata_d;

    mem_size_e         req_size;
    logic [OFS_W-1:0]  req_ofs;
    logic              req_misal, stb_pending, accept, acc_bus, acc_mis;
    logic              resp, push, pop, tag_full, tag_empty;
    logic [NB-1:0]     be_lane;
    logic [DATA_W-1:0] wdata_lane;
    logic [31:0]       lane, load_ext;
    lsu_tag_t          push_tag, head_tag;

    assign req_size    = decode_size(core_sel_i[1:0]);
    assign req_ofs     = core_addr_i[OFS_W-1:0];
    assign req_misal   = misaligned(req_size, core_addr_i[1:0]);
    assign stb_pending = stb_q && wb_stall_i;

    // Misaligned requests only proceed on an idle bus so their error stays in order.
    assign core_gnt_o = !rst && state_q == ST_RUN && !stb_pending && outst_q < MAX_CNT &&
                        !tag_full && (!req_misal || outst_q == '0);

    assign accept  = core_req_i && core_gnt_o;
    assign acc_bus = accept && !req_misal;
    assign acc_mis = accept && req_misal;
    assign resp    = state_q == ST_RUN && (wb_ack_i || wb_err_i) && outst_q != '0;
    assign push    = acc_bus;
    assign pop     = resp || (state_q == ST_ABORT && !tag_empty);

    assign be_lane    = NB'(size_be(req_size)) << req_ofs;
    assign wdata_lane = {(DATA_W/32){core_wdata_i}} << {req_ofs, 3'b000};

    assign push_tag.we   = core_we_i;
    assign push_tag.uns  = core_sel_i[2];
    assign push_tag.size = req_size;
    assign push_tag.ofs  = 3'(req_ofs);

    lsu_tag_fifo #(
        .DEPTH (MAX_OUTST),
        .W     ($bits(lsu_tag_t))
    ) u_tag_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (push),
        .push_dat_i (push_tag),
        .pop_i      (pop),
        .pop_dat_o  (head_tag),
        .full_o     (tag_full),
        .empty_o    (tag_empty)
    );

    assign lane = 32'(wb_dat_i >> {head_tag.ofs, 3'b000});

    always_comb begin
        load_ext = lane;
        case (head_tag.size)
            SZ_B:    load_ext = {{24{!head_tag.uns && lane[7]}}, lane[7:0]};
            SZ_H:    load_ext = {{16{!head_tag.uns && lane[15]}}, lane[15:0]};
            default: load_ext = lane;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        stb_d    = stb_q;
        cyc_d    = 1'b0;
        we_d     = we_q;
        adr_d    = adr_q;
        dat_d    = dat_q;
        sel_d    = sel_q;
        outst_d  = outst_q;
        timer_d  = '0;
        rvalid_d = 1'b0;
        err_d    = 1'b0;
        rdata_d  = '0;
        case (state_q)
            ST_RUN: begin
                if (stb_q && !wb_stall_i) stb_d = 1'b0;
                if (acc_bus) begin
                    stb_d = 1'b1;
                    we_d  = core_we_i;
                    adr_d = {core_addr_i[31:OFS_W], {OFS_W{1'b0}}};
                    dat_d = wdata_lane;
                    sel_d = be_lane;
                end
                if (acc_bus && !resp)      outst_d = outst_q + CNT_W'(1);
                else if (!acc_bus && resp) outst_d = outst_q - CNT_W'(1);
                if (resp) begin
                    rvalid_d = 1'b1;
                    err_d    = wb_err_i;
                    rdata_d  = head_tag.we ? '0 : load_ext;
                end
                if (acc_mis) begin
                    rvalid_d = 1'b1;
                    err_d    = 1'b1;
                end
                if (!resp && outst_q != '0) begin
                    if (timer_q == TMR_LAST) begin
                        state_d = ST_ABORT;
                        stb_d   = 1'b0;
                    end else begin
                        timer_d = timer_q + TMR_W'(1);
                    end
                end
            end
            default: begin
                // Drain one tag per cycle as an error response; the bus is abandoned.
                stb_d = 1'b0;
                if (!tag_empty) begin
                    rvalid_d = 1'b1;
                    err_d    = 1'b1;
                    outst_d  = outst_q - CNT_W'(1);
                end else begin
                    state_d = ST_RUN;
                end
            end
        endcase
        cyc_d = (state_d == ST_RUN) && (stb_d || outst_d != '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_RUN;
            stb_q    <= 1'b0;
            cyc_q    <= 1'b0;
            we_q     <= 1'b0;
            adr_q    <= '0;
            dat_q    <= '0;
            sel_q    <= '0;
            outst_q  <= '0;
            timer_q  <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            stb_q    <= stb_d;
            cyc_q    <= cyc_d;
            we_q     <= we_d;
            adr_q    <= adr_d;
            dat_q    <= dat_d;
            sel_q    <= sel_d;
            outst_q  <= outst_d;
            timer_q  <= timer_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
        end
    end

    assign wb_cyc_o      = cyc_q;
    assign wb_stb_o      = stb_q;
    assign wb_we_o       = we_q;
    assign wb_adr_o      = adr_q;
    assign wb_dat_o      = dat_q;
    assign wb_sel_o      = sel_q;
    assign core_rvalid_o = rvalid_q;
    assign core_rdata_o  = rdata_q;
    assign core_err_o    = err_q;

endmodule
